// File: rtl/tc_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared latency RAM.
// One transaction at a time: IDLE grants, BUSY strobes the RAM until ready or watchdog, RESP acks.
module tc_ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_load,
    output logic              mem_save,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // The watchdog holds the number of completed strobe cycles, 0..TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               lastServed_q, lastServed_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   wdCnt_q, wdCnt_d;
    logic               memLoad_q, memLoad_d;
    logic               memSave_q, memSave_d;
    logic [ADDR_W-1:0]  memAddr_q, memAddr_d;
    logic [DATA_W-1:0]  memIn_q, memIn_d;
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic               pickR1;
    logic               selWe;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selWdata;
    logic               timedOut;

    // On a tie the requester that was not served last wins.
    assign pickR1   = r1_req & (~r0_req | ~lastServed_q);
    assign selWe    = pickR1 ? r1_we    : r0_we;
    assign selAddr  = pickR1 ? r1_addr  : r0_addr;
    assign selWdata = pickR1 ? r1_wdata : r0_wdata;
    assign timedOut = (TIMEOUT > 0) && (wdCnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            lastServed_q <= 1'b1;
            we_q         <= 1'b0;
            wdCnt_q      <= '0;
            memLoad_q    <= 1'b0;
            memSave_q    <= 1'b0;
            memAddr_q    <= '0;
            memIn_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lastServed_q <= lastServed_d;
            we_q         <= we_d;
            wdCnt_q      <= wdCnt_d;
            memLoad_q    <= memLoad_d;
            memSave_q    <= memSave_d;
            memAddr_q    <= memAddr_d;
            memIn_q      <= memIn_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        lastServed_d = lastServed_q;
        we_d         = we_q;
        wdCnt_d      = wdCnt_q;
        memLoad_d    = 1'b0;
        memSave_d    = 1'b0;
        memAddr_d    = '0;
        memIn_d      = '0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    grant_d   = pickR1;
                    we_d      = selWe;
                    wdCnt_d   = '0;
                    memSave_d = selWe;
                    memLoad_d = ~selWe;
                    memAddr_d = selAddr;
                    memIn_d   = selWdata;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                // Ready wins over the watchdog, so ready in the last allowed cycle succeeds.
                if (mem_ready) begin
                    state_d = RESP;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                        if (!we_q) rdata1_d = mem_out;
                    end else begin
                        ack0_d = 1'b1;
                        if (!we_q) rdata0_d = mem_out;
                    end
                end else if (timedOut) begin
                    state_d = RESP;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                        err1_d = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = 1'b1;
                    end
                end else begin
                    wdCnt_d   = wdCnt_q + CNT_W'(1);
                    memSave_d = we_q;
                    memLoad_d = ~we_q;
                    memAddr_d = memAddr_q;
                    memIn_d   = memIn_q;
                end
            end

            RESP: begin
                lastServed_d = grant_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign r0_ack      = ack0_q;
    assign r0_err      = err0_q;
    assign r0_rdata    = rdata0_q;
    assign r1_ack      = ack1_q;
    assign r1_err      = err1_q;
    assign r1_rdata    = rdata1_q;
    assign mem_load    = memLoad_q;
    assign mem_save    = memSave_q;
    assign mem_address = memAddr_q;
    assign mem_in      = memIn_q;

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Self-checking bench for tc_ram_arbiter: transaction-level model of grants, strobe length,
// ack/err and read data, with a latency RAM model driven from the bench.
module tb_tc_ram_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [15:0] r0_addr = '0, r0_wdata = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [15:0] r1_addr = '0, r1_wdata = '0;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [15:0] r0_rdata, r1_rdata;
    logic        mem_load, mem_save;
    logic [15:0] mem_address, mem_in;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_out = '0;

    int          compared = 0;
    int          mismatched = 0;
    bit          lastServed = 1'b1;
    logic [15:0] rd0Exp = '0, rd1Exp = '0;
    logic [15:0] memArr [0:65535];
    int          ramLat = 0;
    int          strobeRun = 0;

    tc_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_load(mem_load), .mem_save(mem_save), .mem_address(mem_address),
        .mem_in(mem_in), .mem_ready(mem_ready), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle, then let the RAM model answer the strobes now visible.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (mem_load || mem_save) begin
            strobeRun++;
            if (strobeRun == ramLat) begin
                mem_ready = 1'b1;
                if (mem_save) memArr[mem_address] = mem_in;
                mem_out = mem_load ? memArr[mem_address] : 16'($urandom);
            end else begin
                mem_ready = 1'b0;
                mem_out = 16'($urandom);
            end
        end else begin
            strobeRun = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_out = 16'($urandom);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".load"}, 32'(mem_load), 32'd0);
        checkOutput({tag, ".save"}, 32'(mem_save), 32'd0);
        checkOutput({tag, ".ack0"}, 32'(r0_ack), 32'd0);
        checkOutput({tag, ".ack1"}, 32'(r1_ack), 32'd0);
    endtask

    // Enter during an IDLE cycle; leaves during the IDLE cycle after RESP.
    task automatic serveOne(input bit q0, input bit q1, input int lat, input bit scramble);
        bit          win;
        bit          wWe;
        logic [15:0] wAddr, wData, expRd;
        bit          succ;
        int          n;
        r0_req = q0;
        r1_req = q1;
        win   = (q0 && q1) ? ~lastServed : q1;
        wWe   = win ? r1_we : r0_we;
        wAddr = win ? r1_addr : r0_addr;
        wData = win ? r1_wdata : r0_wdata;
        succ  = (lat >= 1) && (lat <= TO);
        n     = succ ? lat : TO;
        ramLat = lat;
        for (int i = 1; i <= n; i++) begin
            applyStimulus();
            checkOutput("strobe.save", 32'(mem_save), 32'(wWe));
            checkOutput("strobe.load", 32'(mem_load), 32'(!wWe));
            checkOutput("strobe.addr", 32'(mem_address), 32'(wAddr));
            if (wWe) checkOutput("strobe.in", 32'(mem_in), 32'(wData));
            checkOutput("strobe.acks", 32'({r0_ack, r1_ack}), 32'd0);
            if (scramble) begin
                if (win) begin
                    r1_we = 1'($urandom); r1_addr = 16'($urandom); r1_wdata = 16'($urandom);
                end else begin
                    r0_we = 1'($urandom); r0_addr = 16'($urandom); r0_wdata = 16'($urandom);
                end
            end
        end
        expRd = memArr[wAddr];
        applyStimulus();
        if (succ && !wWe) begin
            if (win) rd1Exp = expRd; else rd0Exp = expRd;
        end
        checkOutput("resp.ack0", 32'(r0_ack), 32'(!win));
        checkOutput("resp.ack1", 32'(r1_ack), 32'(win));
        checkOutput("resp.err0", 32'(r0_err), 32'(!win && !succ));
        checkOutput("resp.err1", 32'(r1_err), 32'(win && !succ));
        checkOutput("resp.rdata0", 32'(r0_rdata), 32'(rd0Exp));
        checkOutput("resp.rdata1", 32'(r1_rdata), 32'(rd1Exp));
        checkOutput("resp.strobes", 32'({mem_load, mem_save}), 32'd0);
        lastServed = win;
        applyStimulus();
        checkQuiet("post");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) memArr[i] = 16'($urandom);
        memArr[1] = 16'h0002;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            r0_req = 1'($urandom); r0_we = 1'($urandom); r0_addr = 16'($urandom); r0_wdata = 16'($urandom);
            r1_req = 1'($urandom); r1_we = 1'($urandom); r1_addr = 16'($urandom); r1_wdata = 16'($urandom);
            applyStimulus();
            checkQuiet("reset");
            checkOutput("reset.errs", 32'({r0_err, r1_err}), 32'd0);
            checkOutput("reset.rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
            checkOutput("reset.addr", 32'({mem_address, mem_in}), 32'd0);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        rst = 1'b0;

        // Directed write and read.
        r0_we = 1'b1; r0_addr = 16'h0000; r0_wdata = 16'h0001;
        serveOne(1'b1, 1'b0, 3, 1'b0);
        r0_req = 1'b0;
        r1_we = 1'b0; r1_addr = 16'h0001;
        serveOne(1'b0, 1'b1, 2, 1'b0);
        checkOutput("read.value", 32'(r1_rdata), 32'h0002);
        checkOutput("read.r0keep", 32'(r0_rdata), 32'h0000);
        r1_req = 1'b0;

        // No requests: nothing happens.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkQuiet("idle");
        end

        // Contention from a fresh reset alternates 0,1,0,1.
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        lastServed = 1'b1; rd0Exp = '0; rd1Exp = '0;
        r0_we = 1'b0; r0_addr = 16'h0010;
        r1_we = 1'b1; r1_addr = 16'h0020; r1_wdata = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            serveOne(1'b1, 1'b1, 1 + (i % 3), 1'b0);
            checkOutput("contend.order", 32'(lastServed), 32'(i % 2));
        end

        // Watchdog: never ready, ready in the last cycle, ready one cycle too late.
        r1_req = 1'b0;
        r0_we = 1'b0; r0_addr = 16'h0020;
        serveOne(1'b1, 1'b0, 0, 1'b0);
        serveOne(1'b1, 1'b0, TO, 1'b0);
        serveOne(1'b1, 1'b0, TO + 1, 1'b0);

        // Reset during the second strobe cycle of a tie the model gives to r1.
        serveOne(1'b1, 1'b0, 1, 1'b0);
        r0_req = 1'b1; r1_req = 1'b1;
        ramLat = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("midrst.strobe", 32'(mem_load | mem_save), 32'd1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkQuiet("midrst");
        checkOutput("midrst.rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
        lastServed = 1'b1; rd0Exp = '0; rd1Exp = '0;
        serveOne(1'b1, 1'b1, 2, 1'b0);
        checkOutput("midrst.firsttie", 32'(lastServed), 32'd0);

        // Randomized traffic against the transaction model.
        for (int i = 0; i < 24; i++) begin
            bit q0, q1;
            q0 = 1'($urandom); q1 = 1'($urandom);
            if (!q0 && !q1) q0 = 1'b1;
            r0_we = 1'($urandom); r0_addr = 16'($urandom_range(0, 7)); r0_wdata = 16'($urandom);
            r1_we = 1'($urandom); r1_addr = 16'($urandom_range(0, 7)); r1_wdata = 16'($urandom);
            serveOne(q0, q1, $urandom_range(0, TO + 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tc_ram_arbiter.md
Name: tc_ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared latency RAM (load/save/address/in0 -> ready/out0 handshake).
- Grants one requester at a time and drives the RAM strobes, address and write data until the RAM asserts ready.
- Returns read data with a one-cycle ack to the granted requester.
- A watchdog aborts transactions that never complete.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.
- TIMEOUT, 64, maximum strobe cycles before abort. A value of 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- r0_req  in  1  requester 0 request level
- r0_we  in  1  1=write (save), 0=read (load)
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_ack  out  1  one-cycle completion pulse
- r0_err  out  1  pulses with r0_ack on timeout abort
- r0_rdata  out  DATA_W  read result, valid with r0_ack
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as requester 0, for requester 1
- mem_load  out  1  to RAM load
- mem_save  out  1  to RAM save
- mem_address  out  ADDR_W  to RAM address
- mem_in  out  DATA_W  to RAM in0
- mem_ready  in  1  from RAM ready
- mem_out  in  DATA_W  from RAM out0

Behaviour:
- Reset values: all outputs 0; state IDLE; last-served pointer = 1, so requester 0 wins the first tie; watchdog counter 0.
- Requester protocol:
  - Assert req with we/addr/wdata and hold all stable up to and including the cycle ack=1.
  - req high in the cycle after ack is a new request.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req is high, grant per round-robin.
    - Only one requesting: grant it.
    - Both requesting: grant the one that is not last-served.
  - Latch we/addr/wdata and the grant id.
  - Next state BUSY.
  - No grant and no outputs change when no req is high.
- BUSY:
  - Registered strobes drive the RAM. mem_save=we and mem_load=~we.
  - mem_address and mem_in come from the latched fields, held constant.
  - mem_load and mem_save are never both 1.
  - Watchdog counts strobe cycles.
  - On mem_ready=1: capture mem_out for reads, then go to RESP with err=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT strobe cycles without ready: go to RESP with err=1.
  - Ready in the final allowed cycle counts as success.
- RESP (exactly one cycle):
  - Strobes are 0.
  - Granted requester's ack=1, and err as determined in BUSY.
  - rdata is updated only on a successful read.
  - rdata holds its value across writes, errors and idle cycles until that requester's next successful read ack.
  - last-served <= grant id.
  - Next state IDLE. No new grant is made in RESP.
- Timing: req seen in cycle 0 -> strobe high in cycles 1..k, where ready is seen in cycle k -> ack in cycle k+1 -> earliest next grant in cycle k+2, strobe in cycle k+3.
- Timeout timing: strobe cycles 1..TIMEOUT, ack+err in cycle TIMEOUT+1.
- mem_ready outside BUSY is ignored.
- Requester changing fields while granted has no effect, because the latched copy is used.
- Reset mid-operation:
  - rst sampled high forces all outputs to 0 on that edge and discards the transaction; no ack is issued.
  - Pointer returns to 1 and rdata registers clear.
- Back-to-back with both req held continuously: service alternates 0,1,0,1.
- One requester alone is served repeatedly with no forced idle beyond RESP.

Test Plan:
1. Reset: hold rst 5 cycles with random inputs -> every output 0, no strobe.
2. Write: r0_req, we=1, addr=0x0000, wdata=0x0001; RAM model ready 3 cycles after strobe -> mem_save=1, mem_address=0x0000, mem_in=0x0001 for 3 cycles; r0_ack=1 and r0_err=0 the next cycle; mem_save=0 in the ack cycle.
3. Read: r1_req, we=0, addr=0x0001, model returns 0x0002 -> mem_load held until ready; r1_ack pulse with r1_rdata=0x0002; r0_rdata unchanged.
4. Contention: r0_req and r1_req both held for 4 transactions from reset -> grant order r0,r1,r0,r1; strobes never overlap; exactly one ack per RESP.
5. Timeout: TIMEOUT=8, mem_ready held 0 -> strobe high exactly 8 cycles, then ack=1 and err=1 in cycle 9; rdata unchanged. With ready arriving in cycle 8 -> err=0.
6. Reset mid-BUSY: assert rst during the 2nd strobe cycle -> strobes 0 on the next edge, no ack; after release the first tie goes to r0.
